// File: rtl/mult_share_arb.sv
// Two-port round-robin arbiter sharing one real-times-complex multiplier; an in-flight ID FIFO
// steers each product packet back to its requester. Define MULT_SHARE_ARB_STATS_EN for per-port grant counters.

module mult_share_arb #(
    parameter int WIDTH_REAL    = 25,
    parameter int WIDTH_CPLX    = 18,
    parameter int WIDTH_P       = 48,
    parameter int ID_DEPTH_LOG2 = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
`ifdef MULT_SHARE_ARB_STATS_EN
    output logic [31:0]                        pkt_cnt0,
    output logic [31:0]                        pkt_cnt1,
`endif
    input  logic [WIDTH_REAL+2*WIDTH_CPLX-1:0] s0_tdata,
    input  logic                               s0_tlast,
    input  logic                               s0_tvalid,
    output logic                               s0_tready,
    input  logic [WIDTH_REAL+2*WIDTH_CPLX-1:0] s1_tdata,
    input  logic                               s1_tlast,
    input  logic                               s1_tvalid,
    output logic                               s1_tready,
    output logic [WIDTH_REAL-1:0]              mult_real_tdata,
    output logic [2*WIDTH_CPLX-1:0]            mult_cplx_tdata,
    output logic                               mult_tlast,
    output logic                               mult_tvalid,
    input  logic                               mult_tready,
    input  logic [2*WIDTH_P-1:0]               mult_p_tdata,
    input  logic                               mult_p_tlast,
    input  logic                               mult_p_tvalid,
    output logic                               mult_p_tready,
    output logic [2*WIDTH_P-1:0]               p0_tdata,
    output logic                               p0_tlast,
    output logic                               p0_tvalid,
    input  logic                               p0_tready,
    output logic [2*WIDTH_P-1:0]               p1_tdata,
    output logic                               p1_tlast,
    output logic                               p1_tvalid,
    input  logic                               p1_tready
);

    localparam int DW    = WIDTH_REAL + 2*WIDTH_CPLX;
    localparam int DEPTH = 1 << ID_DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                   state, state_nxt;
    logic                     rr_ptr;
    logic                     push, pop, pkt_done, grant_sel;
    logic                     fifo_full, fifo_empty, head_id;
    logic [ID_DEPTH_LOG2:0]   id_count;
    logic [ID_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                     id_mem [DEPTH];

    // Count is one bit wider than the pointers; its MSB alone marks a full FIFO.
    assign fifo_full  = id_count[ID_DEPTH_LOG2];
    assign fifo_empty = (id_count == '0);
    assign head_id    = id_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pkt_done)
                rr_ptr <= (state == GRANT0);
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pkt_done  = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if ((s0_tvalid || s1_tvalid) && !fifo_full) begin
                    grant_sel = (s0_tvalid && s1_tvalid) ? rr_ptr : s1_tvalid;
                    push      = 1'b1;
                    state_nxt = grant_sel ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                pkt_done = s0_tvalid && mult_tready && s0_tlast;
                if (pkt_done)
                    state_nxt = IDLE;
            end
            GRANT1: begin
                pkt_done = s1_tvalid && mult_tready && s1_tlast;
                if (pkt_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mult_real_tdata = '0;
        mult_cplx_tdata = '0;
        mult_tlast      = 1'b0;
        mult_tvalid     = 1'b0;
        s0_tready       = 1'b0;
        s1_tready       = 1'b0;
        case (state)
            GRANT0: begin
                mult_real_tdata = s0_tdata[DW-1 -: WIDTH_REAL];
                mult_cplx_tdata = s0_tdata[2*WIDTH_CPLX-1:0];
                mult_tlast      = s0_tlast;
                mult_tvalid     = s0_tvalid;
                s0_tready       = mult_tready;
            end
            GRANT1: begin
                mult_real_tdata = s1_tdata[DW-1 -: WIDTH_REAL];
                mult_cplx_tdata = s1_tdata[2*WIDTH_CPLX-1:0];
                mult_tlast      = s1_tlast;
                mult_tvalid     = s1_tvalid;
                s1_tready       = mult_tready;
            end
            default: ;
        endcase
    end

    // Product return path: the head ID picks the destination; nothing is routed while the FIFO is empty.
    always_comb begin
        mult_p_tready = 1'b0;
        p0_tdata      = '0;
        p0_tlast      = 1'b0;
        p0_tvalid     = 1'b0;
        p1_tdata      = '0;
        p1_tlast      = 1'b0;
        p1_tvalid     = 1'b0;
        if (!fifo_empty) begin
            if (head_id) begin
                mult_p_tready = p1_tready;
                p1_tdata      = mult_p_tdata;
                p1_tlast      = mult_p_tlast;
                p1_tvalid     = mult_p_tvalid;
            end else begin
                mult_p_tready = p0_tready;
                p0_tdata      = mult_p_tdata;
                p0_tlast      = mult_p_tlast;
                p0_tvalid     = mult_p_tvalid;
            end
        end
    end

    assign pop = mult_p_tvalid && mult_p_tready && mult_p_tlast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            id_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   id_count <= id_count + 1'b1;
                2'b01:   id_count <= id_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: ID storage has no reset; only entries below id_count are ever read, and reset clears the count.
    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= grant_sel;
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (push) begin
            if (grant_sel)
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            else
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter WIDTH_REAL, default 25: real operand width.
REQ-002 SHALL have parameter WIDTH_CPLX, default 18: per-component complex operand width.
REQ-003 SHALL have parameter WIDTH_P, default 48: per-component product width.
REQ-004 SHALL have parameter ID_DEPTH_LOG2, default 3: log2 of the in-flight packet ID FIFO depth (8).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports s0_tdata / s1_tdata  in  WIDTH_REAL+2*WIDTH_CPLX  requester operands {real, cplx_i, cplx_q}.
REQ-008 SHALL have ports s0_tlast, s0_tvalid / s1_tlast, s1_tvalid  in  1 each  requester framing and valid.
REQ-009 SHALL have ports s0_tready / s1_tready  out  1 each  requester ready.
REQ-010 SHALL have ports mult_real_tdata  out  WIDTH_REAL, and mult_cplx_tdata  out  2*WIDTH_CPLX  operands to the shared real-times-complex multiplier.
REQ-011 SHALL have ports mult_tlast, mult_tvalid  out  1 each, and mult_tready  in  1  operand handshake; valid drives both multiplier inputs.
REQ-012 SHALL have ports mult_p_tdata  in  2*WIDTH_P, mult_p_tlast, mult_p_tvalid  in  1 each, and mult_p_tready  out  1  multiplier product stream.
REQ-013 SHALL have ports p0_tdata / p1_tdata  out  2*WIDTH_P, p0_tlast, p0_tvalid, p1_tlast, p1_tvalid  out  1 each, and p0_tready / p1_tready  in  1 each  per-requester product outputs.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-015 IDLE: if any sN_tvalid=1 and the ID FIFO is not full (registered count), SHALL select a port by round-robin pointer (pointer port wins ties), push its ID, and enter GRANTN next cycle.
REQ-016 GRANTN: mult_tvalid=sN_tvalid, sN_tready=mult_tready, mult data/tlast = port N; the other port's tready=0.
REQ-017 GRANTN SHALL return to IDLE on an accepted beat with sN_tlast=1, setting the pointer to the other port; grants never change mid-packet.
REQ-018 In IDLE, mult_tvalid, s0_tready and s1_tready SHALL be 0; one idle cycle always separates granted packets.
REQ-019 A push SHALL be blocked when the FIFO is full, even if a pop occurs in the same cycle.
REQ-020 Return path SHALL route mult_p_* combinationally to port pK, where K is the ID at the FIFO head; the other port's valid=0.
REQ-021 mult_p_tready SHALL equal pK_tready when the FIFO is non-empty, else 0.
REQ-022 The FIFO SHALL pop on an accepted product beat with mult_p_tlast=1; simultaneous push and pop SHALL leave the count unchanged.
REQ-023 Added latency SHALL be 0 cycles on data, beyond the 1-cycle grant decision.

Reset
REQ-024 On reset_n=0, state SHALL be IDLE, pointer=0 and FIFO empty, asynchronously.
REQ-025 Reset SHALL drive all tvalid/tready outputs to 0 and all tdata/tlast outputs to 0.
REQ-026 A reset mid-packet SHALL discard the grant and all in-flight IDs; operation resumes from IDLE after release.

Configuration
REQ-027 When macro MULT_SHARE_ARB_STATS_EN is defined, SHALL add outputs pkt_cnt0 / pkt_cnt1 (out, 32 bits each), incremented on each grant to that port, wrapping at 2^32-1, and reset to 0.
REQ-028 When MULT_SHARE_ARB_STATS_EN is undefined, those ports and counters SHALL be absent, with no other change.

Verification
REQ-029 Both ports hold valid 3-beat packets, with mult_tready=1 and a 3-cycle-latency multiplier model -> grants alternate 0,1,0,1; each product packet arrives only on its own pN.
REQ-030 Only s1 valid, with pointer=0 -> s1 is granted after 1 IDLE cycle; s0_tready stays 0.
REQ-031 mult_p_tready held 0, with 9 single-beat packets offered -> 8 grants; the 9th is stalled until the first product's tlast pops the FIFO.
REQ-032 p0_tready=0 with the head ID=0 -> mult_p_tready=0; a p1-bound product behind it is not delivered until p0 accepts.
REQ-033 reset_n asserted on beat 2 of a 4-beat packet -> all readies and valids go 0 immediately; FIFO empty and pointer=0 after release.
REQ-034 With MULT_SHARE_ARB_STATS_EN defined, 5 packets on s0 and 2 on s1 -> pkt_cnt0=5, pkt_cnt1=2.
